divider16: RTL

Unsigned 16-bit sequential divider: the inverse companion to the ripple-carry `FullAdder16` datapath in the Hack ALU family. It computes quotient and remainder by restoring shift-subtract, one quotient bit per clock, and reuses an adder-width (17-bit) subtract per step. It sits beside the ALU as a multi-cycle coprocessor with a start/busy/done handshake.

---
 rtl/divider16.sv | 109 ++++++++++
 1 files changed

// File: rtl/divider16.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Start/busy/done handshake; results held in dedicated registers between operations.
module divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    step, step_n;
    logic [WIDTH-1:0] r_work, r_work_n;
    logic [WIDTH-1:0] q_work, q_work_n;
    logic [WIDTH-1:0] dvsr, dvsr_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic             div_by_zero_n;

    // One restoring step: shift the next dividend bit into R, trial-subtract the divisor.
    // R stays below 2^k after k steps, so dropping R's MSB on the shift loses nothing.
    logic [WIDTH-1:0] trial;
    logic [WIDTH:0]   diff;
    logic             qbit;

    assign trial = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
    assign diff  = {1'b0, trial} - {1'b0, dvsr};
    assign qbit  = ~diff[WIDTH];

    // Handshake: start is accepted only when busy=0 (IDLE or DONE); done pulses for
    // exactly one cycle with results valid; busy and done are mutually exclusive.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n       = state;
        step_n        = step;
        r_work_n      = r_work;
        q_work_n      = q_work;
        dvsr_n        = dvsr;
        quotient_n    = quotient;
        remainder_n   = remainder;
        div_by_zero_n = div_by_zero;
        case (state)
            RUN: begin
                r_work_n = qbit ? diff[WIDTH-1:0] : trial;
                q_work_n = {q_work[WIDTH-2:0], qbit};
                step_n   = step + 1'b1;
                if (step == LAST_STEP) begin
                    state_n       = DONE;
                    quotient_n    = {q_work[WIDTH-2:0], qbit};
                    remainder_n   = qbit ? diff[WIDTH-1:0] : trial;
                    div_by_zero_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                if (start) begin
                    dvsr_n = divisor;
                    if (divisor == '0) begin
                        state_n       = DONE;
                        quotient_n    = '1;
                        remainder_n   = dividend;
                        div_by_zero_n = 1'b1;
                    end else begin
                        state_n  = RUN;
                        step_n   = '0;
                        r_work_n = '0;
                        q_work_n = dividend;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            r_work      <= '0;
            q_work      <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            r_work      <= r_work_n;
            q_work      <= q_work_n;
            dvsr        <= dvsr_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= div_by_zero_n;
        end
    end

endmodule
